// File: rtl/prng_range_sampler.sv
// prng_range_sampler: reduces a free-running PRNG word to a uniform value in [0, limit) by mask-and-reject,
// buffered in a FIFO behind a valid/ready stream. Define PRNG_SAMPLER_STATS_EN for reject/drop counters.
module prng_range_sampler #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] rnd_i,
  input  logic             en_i,
  input  logic             cfg_we_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] reject_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] limit_q, mask_q, mask_d, cand_q, cand_d, head_q, head_d;
  logic acc_q, acc_d, stage_v_q, stage_v_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_d;
  logic [AW:0] cnt_q, cnt_d, left;
  logic flush, pop, take, push;
  // Smear limit-1 rightwards: yields the smallest 2^k-1 covering it (limit 0 wraps to all-ones).
  always_comb begin
    mask_d = limit_q - 1'b1;
    for (int i = 0; i < WIDTH; i++) mask_d = mask_d | (mask_d >> 1);
  end
  always_comb begin
    state_d   = cfg_we_i ? FLUSH : en_i ? RUN : IDLE;
    cand_d    = rnd_i & mask_q;
    acc_d     = (limit_q == '0) || (cand_d < limit_q);
    stage_v_d = (state_q == RUN) && !cfg_we_i;
    flush     = cfg_we_i || (state_q == FLUSH);
    pop       = out_valid_o && out_ready_i;
    left      = cnt_q - (AW+1)'(pop);
    take      = stage_v_q && acc_q && !flush;
    push      = take && (left < FULL);
    rd_d      = rd_q + AW'(pop);
    cnt_d     = flush ? '0 : left + (AW+1)'(push);
    head_d    = (cnt_d != '0) ? ((left == '0) ? cand_q : mem_q[rd_d]) : head_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      mask_q    <= '1;
      cand_q    <= '0;
      acc_q     <= 1'b0;
      stage_v_q <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
    end else begin
      state_q   <= state_d;
      limit_q   <= cfg_we_i ? limit_i : limit_q;
      mask_q    <= mask_d;
      cand_q    <= cand_d;
      acc_q     <= acc_d;
      stage_v_q <= stage_v_d;
      rd_q      <= flush ? '0 : rd_d;
      wr_q      <= flush ? '0 : wr_q + AW'(push);
      cnt_q     <= cnt_d;
      head_q    <= head_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= cand_q;
  end
  assign out_valid_o = cnt_q != '0;
  assign out_data_o  = head_q;
`ifdef PRNG_SAMPLER_STATS_EN
  logic [CNT_W-1:0] rej_q, drop_q;
  logic reject, drop;
  assign reject = stage_v_q && !acc_q && !flush;
  assign drop   = take && (left == FULL);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rej_q  <= '0;
      drop_q <= '0;
    end else begin
      rej_q  <= rej_q + CNT_W'(reject && !(&rej_q));
      drop_q <= drop_q + CNT_W'(drop && !(&drop_q));
    end
  end
  assign reject_cnt_o = rej_q;
  assign drop_cnt_o   = drop_q;
`else
  assign reject_cnt_o = '0;
  assign drop_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_prng_range_sampler.sv
// tb_prng_range_sampler: randomized stimulus against a queue-based reference model; a negedge monitor
// compares the DUT stream with the expected-value scoreboard.
module tb_prng_range_sampler;
  localparam int W = 16;
  localparam int D = 4;
  localparam int CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;
  localparam int unsigned WMAX = (1 << W) - 1;
`ifdef PRNG_SAMPLER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic en_i = 1'b0;
  logic cfg_we_i = 1'b0;
  logic out_ready_i = 1'b0;
  logic out_valid_o;
  logic [W-1:0] rnd_i = '0;
  logic [W-1:0] limit_i = '0;
  logic [W-1:0] out_data_o;
  logic [CW-1:0] reject_cnt_o, drop_cnt_o;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  prng_range_sampler #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rnd_i(rnd_i), .en_i(en_i), .cfg_we_i(cfg_we_i),
    .limit_i(limit_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .reject_cnt_o(reject_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  task automatic chk(input string n, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: enabled-state, one-cycle sampling stage, bounded FIFO occupancy.
  int mstate, mcnt;
  int unsigned mlim, mmask, st_c, rej, drp;
  bit st_v, st_a, fl;
  logic [W-1:0] sb[$];

  function automatic int unsigned mask_for(input int unsigned lim);
    int unsigned m = 1;
    if (lim == 0) return WMAX;
    while (m - 1 < lim - 1) m = m * 2;
    return m - 1;
  endfunction

  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni) begin
      mstate = 0; mcnt = 0; mlim = 0; mmask = WMAX;
      st_v = 0; st_a = 0; st_c = 0; rej = 0; drp = 0;
      sb.delete();
    end else begin
      fl = cfg_we_i || mstate == 2;
      if (mcnt > 0 && out_ready_i) mcnt--;
      if (fl) begin
        mcnt = 0;
        sb.delete();
      end else if (st_v && !st_a) begin
        if (rej < CMAX) rej++;
      end else if (st_v && mcnt < D) begin
        sb.push_back(W'(st_c));
        mcnt++;
      end else if (st_v) begin
        if (drp < CMAX) drp++;
      end
      st_v = mstate == 1 && !cfg_we_i;
      st_c = int'(rnd_i) & mmask;
      st_a = mlim == 0 || st_c < mlim;
      mmask = mask_for(mlim);
      if (cfg_we_i) mlim = int'(limit_i);
      mstate = cfg_we_i ? 2 : en_i ? 1 : 0;
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      chk("valid", 32'(out_valid_o), 32'(mcnt != 0));
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data: got %0h expected no output at %0t", out_data_o, $time);
        end else begin
          chk("data", 32'(out_data_o), 32'(sb[0]));
          if (out_ready_i) void'(sb.pop_front());
        end
      end
      chk("reject_cnt", 32'(reject_cnt_o), STATS ? rej : 0);
      chk("drop_cnt", 32'(drop_cnt_o), STATS ? drp : 0);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input logic [W-1:0] lim);
    cfg_we_i = 1'b1;
    limit_i = lim;
    step();
    cfg_we_i = 1'b0;
  endtask

  int unsigned lims[6] = '{0, 1, 2, 5, 7, 'h100};
  logic [W-1:0] seq[4] = '{16'h0003, 16'h0006, 16'hFFF4, 16'h0007};

  initial begin
    step();
    step();
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_data", 32'(out_data_o), 0);
    chk("rst_rej", 32'(reject_cnt_o), 0);
    chk("rst_drop", 32'(drop_cnt_o), 0);
    rst_ni = 1'b1;
    en_i = 1'b1;
    out_ready_i = 1'b1;
    step();
    rnd_i = 16'h1234;
    step();
    rnd_i = 16'h5678;
    step();
    chk("lat_valid", 32'(out_valid_o), 1);
    chk("lat_data", 32'(out_data_o), 32'h1234);
    for (int i = 2; i < 10; i++) begin
      rnd_i = W'(32'h1234 + 32'h4444 * i);
      step();
    end
    cfg(16'd5);
    rnd_i = W'($urandom);
    step();
    for (int i = 0; i < 4; i++) begin
      rnd_i = seq[i];
      step();
    end
    en_i = 1'b0;
    rnd_i = 16'h0007;
    for (int i = 0; i < 4; i++) step();
    en_i = 1'b1;
    cfg(16'd1);
    for (int i = 0; i < 20; i++) begin
      rnd_i = W'($urandom);
      step();
    end
    en_i = 1'b0;
    cfg(16'd0);
    for (int i = 0; i < 3; i++) step();
    out_ready_i = 1'b0;
    en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rnd_i = W'($urandom);
      step();
    end
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    out_ready_i = 1'b0;
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_i = W'($urandom);
      step();
    end
    en_i = 1'b0;
    for (int i = 0; i < 10 && mcnt < 3; i++) step();
    chk("fill3", 32'(mcnt), 3);
    out_ready_i = 1'b1;
    cfg(16'h0100);
    chk("flush_empty", 32'(out_valid_o), 0);
    en_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rnd_i = W'($urandom);
      out_ready_i = $urandom_range(0, 2) != 0;
      if (out_valid_o) chk("below_limit", 32'(out_data_o < 16'h0100), 1);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      rnd_i = W'($urandom);
      en_i = $urandom_range(0, 3) != 0;
      out_ready_i = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 19) == 0) begin
        cfg_we_i = 1'b1;
        limit_i = $urandom_range(0, 1) != 0 ? W'(lims[$urandom_range(0, 5)]) : W'($urandom);
      end else begin
        cfg_we_i = 1'b0;
      end
      step();
    end
    cfg_we_i = 1'b0;
    cfg(16'd0);
    en_i = 1'b1;
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rnd_i = W'($urandom);
      step();
    end
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 0);
    chk("arst_data", 32'(out_data_o), 0);
    chk("arst_rej", 32'(reject_cnt_o), 0);
    chk("arst_drop", 32'(drop_cnt_o), 0);
    en_i = 1'b0;
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("idle_valid", 32'(out_valid_o), 0);
    en_i = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_i = W'($urandom);
      step();
    end
    chk("rearm_valid", 32'(out_valid_o), 1);
    en_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
